// File: rtl/riscv_imem_pkg.sv
// Shared types and constants for the instruction memory: loader/run state,
// the NOP returned when nothing valid has been fetched, and byte-lane assembly.
package riscv_imem_pkg;

    typedef enum logic [0:0] {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Earlier bytes are shifted in from the top, so the oldest byte sits lowest
    // once three lanes are held; a short final word is zero-filled above `data`.
    function automatic logic [31:0] assemble_word(
        input logic [1:0]  lane,
        input logic [7:0]  data,
        input logic [23:0] held
    );
        logic [31:0] word;
        case (lane)
            2'd0:    word = {24'h00_0000, data};
            2'd1:    word = {16'h0000, data, held[23:16]};
            2'd2:    word = {8'h00, data, held[23:8]};
            2'd3:    word = {data, held};
            default: word = INST_NOP;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/riscv_imem_ram.sv
// Simple dual-port DEPTH x 32 RAM: one synchronous write port and one
// registered read port, written so synthesis maps it onto block RAM.
module riscv_imem_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Write port and registered read port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/riscv_imem.sv
// Instruction memory: filled by a little-endian byte-stream loader, then
// serves single-cycle-latency fetches with out-of-range fault reporting.
module riscv_imem
    import riscv_imem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_fault,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        load_done,
    output logic        ld_overflow
);

    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] WR_LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     PC_LIMIT = 32'(DEPTH);

    imem_state_t       state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       lanes_q, lanes_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic              ld_overflow_q, ld_overflow_d;
    logic              load_done_q, load_done_d;
    logic              ld_ready_q, ld_ready_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic              sel_nop_q, sel_nop_d;

    logic              accept_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic [31:0]       ram_wdata_s;
    logic [31:0]       ram_rdata_s;

    // Next-state logic for the loader FSM, byte assembly and fetch path.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        lanes_d       = lanes_q;
        wr_ptr_d      = wr_ptr_q;
        ld_overflow_d = ld_overflow_q;
        load_done_d   = load_done_q;
        ld_ready_d    = ld_ready_q;
        inst_valid_d  = 1'b0;
        fetch_fault_d = 1'b0;
        sel_nop_d     = sel_nop_q;
        accept_s      = 1'b0;
        ram_we_s      = 1'b0;
        ram_re_s      = 1'b0;
        ram_wdata_s   = assemble_word(byte_cnt_q, ld_data, lanes_q);

        case (state_q)
            IMEM_LOAD: begin
                accept_s = ld_valid & ld_ready_q;
                if (accept_s) begin
                    lanes_d = {ld_data, lanes_q[23:8]};
                    if ((byte_cnt_q == 2'd3) || ld_last) begin
                        // A full memory swallows further words but keeps accepting bytes.
                        if (wr_ptr_q == WR_LIMIT) begin
                            ld_overflow_d = 1'b1;
                        end else begin
                            ram_we_s = 1'b1;
                            wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
                        end
                    end else begin
                        ram_we_s = 1'b0;
                    end
                    if (ld_last) begin
                        byte_cnt_d  = 2'd0;
                        state_d     = IMEM_RUN;
                        load_done_d = 1'b1;
                        ld_ready_d  = 1'b0;
                    end else begin
                        byte_cnt_d  = byte_cnt_q + 2'd1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            IMEM_RUN: begin
                if (fetch_en) begin
                    inst_valid_d = 1'b1;
                    if (pc >= PC_LIMIT) begin
                        fetch_fault_d = 1'b1;
                        sel_nop_d     = 1'b1;
                    end else begin
                        ram_re_s      = 1'b1;
                        sel_nop_d     = 1'b0;
                    end
                end else begin
                    inst_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IMEM_LOAD;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IMEM_LOAD;
            byte_cnt_q    <= 2'd0;
            lanes_q       <= 24'h00_0000;
            wr_ptr_q      <= '0;
            ld_overflow_q <= 1'b0;
            load_done_q   <= 1'b0;
            ld_ready_q    <= 1'b1;
            inst_valid_q  <= 1'b0;
            fetch_fault_q <= 1'b0;
            sel_nop_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            lanes_q       <= lanes_d;
            wr_ptr_q      <= wr_ptr_d;
            ld_overflow_q <= ld_overflow_d;
            load_done_q   <= load_done_d;
            ld_ready_q    <= ld_ready_d;
            inst_valid_q  <= inst_valid_d;
            fetch_fault_q <= fetch_fault_d;
            sel_nop_q     <= sel_nop_d;
        end
    end

    riscv_imem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

    // The RAM read register holds its value when idle, so selecting NOP by a
    // flag keeps inst stable without a separate 32-bit output register.
    assign inst        = sel_nop_q ? INST_NOP : ram_rdata_s;
    assign inst_valid  = inst_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign ld_ready    = ld_ready_q;
    assign load_done   = load_done_q;
    assign ld_overflow = ld_overflow_q;

endmodule
